// File: rtl/flash_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// flash_cmd_decoder_if
// Bundles the command-side inputs and the flash-controller request outputs
// of flash_cmd_decoder.
//   cmd         : command word [31:24] opcode, [23:16] sub-index, [15:0] payload
//   start_cmd   : command framing level; a word is taken on its rising edge
//   op_done     : one-cycle completion pulse from the flash controller
//   op_start    : one-cycle operation request pulse
//   op_type     : 01 write, 10 read, 11 erase, 00 idle
//   op_addr     : operation start address
//   op_end_addr : erase end address (equals op_addr for write/read)
//   busy        : high while an operation is in flight
//   cmd_err     : one-cycle pulse on a rejected command
//   op_timeout  : one-cycle pulse when an operation is abandoned
// master = command source / flash controller side, slave = the decoder.
// ---------------------------------------------------------------------------
interface flash_cmd_decoder_if;
   logic [31:0] cmd;
   logic        start_cmd;
   logic        op_done;
   logic        op_start;
   logic [1:0]  op_type;
   logic [23:0] op_addr;
   logic [23:0] op_end_addr;
   logic        busy;
   logic        cmd_err;
   logic        op_timeout;

   modport master (
      output cmd, start_cmd, op_done,
      input  op_start, op_type, op_addr, op_end_addr, busy, cmd_err, op_timeout
   );

   modport slave (
      input  cmd, start_cmd, op_done,
      output op_start, op_type, op_addr, op_end_addr, busy, cmd_err, op_timeout
   );
endinterface

// File: rtl/flash_cmd_decoder.sv
// ---------------------------------------------------------------------------
// flash_cmd_decoder
// Captures framed 32-bit command words, assembles write/read/erase address
// shadows from AF/AD/AE sub-commands and launches one operation at a time to
// the NAND flash controller, tracking it until op_done or timeout.
// Ports:
//   clk  : rising-edge system clock
//   rst  : asynchronous active-high reset
//   bus  : flash_cmd_decoder_if.slave (command inputs, operation outputs)
// Parameter:
//   TIMEOUT_CYC : clocks allowed in RUN before the operation is abandoned
// ---------------------------------------------------------------------------
module flash_cmd_decoder #(
   parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
   input logic                 clk,
   input logic                 rst,
   flash_cmd_decoder_if.slave  bus
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t      state_q;
   logic [31:0] cnt_q;
   logic        start_cmd_d;
   logic        armed_q;
   logic        cmd_vld_q;
   logic [31:0] cmd_q;

   logic [23:0] wr_addr_q, rd_addr_q, er_start_q, er_end_q;
   logic        wr_hi_v_q, wr_lo_v_q, rd_hi_v_q, rd_lo_v_q;
   logic        es_hi_v_q, es_lo_v_q, ee_hi_v_q, ee_lo_v_q;

   logic        op_start_q, busy_q, cmd_err_q, op_timeout_q;
   logic [1:0]  op_type_q;
   logic [23:0] op_addr_q, op_end_addr_q;

   logic        pos_s, known_s;
   logic        ld_wr_hi_s, ld_wr_lo_s, ld_rd_hi_s, ld_rd_lo_s;
   logic        ld_es_hi_s, ld_es_lo_s, ld_ee_hi_s, ld_ee_lo_s;
   logic        want_wr_s, want_rd_s, want_er_s;
   logic        idle_s, wr_ok_s, rd_ok_s, er_ok_s;
   logic        acc_wr_s, acc_rd_s, acc_er_s, reject_s;
   logic [23:0] rd_launch_addr_s, er_end_new_s;

   // armed_q blocks a capture when start_cmd is already high as reset releases
   assign pos_s = bus.start_cmd & ~start_cmd_d & armed_q;

   // Decode the captured word into shadow loads, launch requests and verdicts
   always_comb begin
      known_s    = 1'b1;
      ld_wr_hi_s = 1'b0;
      ld_wr_lo_s = 1'b0;
      ld_rd_hi_s = 1'b0;
      ld_rd_lo_s = 1'b0;
      ld_es_hi_s = 1'b0;
      ld_es_lo_s = 1'b0;
      ld_ee_hi_s = 1'b0;
      ld_ee_lo_s = 1'b0;
      want_wr_s  = 1'b0;
      want_rd_s  = 1'b0;
      want_er_s  = 1'b0;
      case (cmd_q[31:16])
         16'hAF00: ld_wr_hi_s = 1'b1;
         16'hAF01: ld_wr_lo_s = 1'b1;
         16'hA000: want_wr_s  = 1'b1;
         16'hAD00: ld_rd_hi_s = 1'b1;
         16'hAD01: begin
            ld_rd_lo_s = 1'b1;
            want_rd_s  = 1'b1;
         end
         16'hAE00: ld_es_hi_s = 1'b1;
         16'hAE01: ld_es_lo_s = 1'b1;
         16'hAE02: ld_ee_hi_s = 1'b1;
         16'hAE03: begin
            ld_ee_lo_s = 1'b1;
            want_er_s  = 1'b1;
         end
         default:  known_s = 1'b0;
      endcase
      // Read and erase launch on the word that also loads the low byte, so
      // they are judged against the value being loaded right now.
      rd_launch_addr_s = {rd_addr_q[23:8], cmd_q[15:8]};
      er_end_new_s     = {er_end_q[23:8], cmd_q[15:8]};
      idle_s   = (state_q == S_IDLE);
      wr_ok_s  = wr_hi_v_q & wr_lo_v_q;
      rd_ok_s  = rd_hi_v_q;
      er_ok_s  = es_hi_v_q & es_lo_v_q & ee_hi_v_q & (er_end_new_s >= er_start_q);
      acc_wr_s = cmd_vld_q & want_wr_s & wr_ok_s & idle_s;
      acc_rd_s = cmd_vld_q & want_rd_s & rd_ok_s & idle_s;
      acc_er_s = cmd_vld_q & want_er_s & er_ok_s & idle_s;
      reject_s = cmd_vld_q & (~known_s
                 | (want_wr_s & ~(wr_ok_s & idle_s))
                 | (want_rd_s & ~(rd_ok_s & idle_s))
                 | (want_er_s & ~(er_ok_s & idle_s)));
   end

   // Capture, shadow registers, operation FSM and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= 32'd0;
         start_cmd_d   <= 1'b0;
         armed_q       <= 1'b0;
         cmd_vld_q     <= 1'b0;
         cmd_q         <= 32'd0;
         wr_addr_q     <= 24'd0;
         rd_addr_q     <= 24'd0;
         er_start_q    <= 24'd0;
         er_end_q      <= 24'd0;
         wr_hi_v_q     <= 1'b0;
         wr_lo_v_q     <= 1'b0;
         rd_hi_v_q     <= 1'b0;
         rd_lo_v_q     <= 1'b0;
         es_hi_v_q     <= 1'b0;
         es_lo_v_q     <= 1'b0;
         ee_hi_v_q     <= 1'b0;
         ee_lo_v_q     <= 1'b0;
         op_start_q    <= 1'b0;
         op_type_q     <= 2'b00;
         op_addr_q     <= 24'd0;
         op_end_addr_q <= 24'd0;
         busy_q        <= 1'b0;
         cmd_err_q     <= 1'b0;
         op_timeout_q  <= 1'b0;
      end else begin
         start_cmd_d  <= bus.start_cmd;
         armed_q      <= armed_q | ~bus.start_cmd;
         cmd_vld_q    <= pos_s;
         if (pos_s) cmd_q <= bus.cmd;
         op_start_q   <= 1'b0;
         op_timeout_q <= 1'b0;
         cmd_err_q    <= reject_s;

         // Shadow loads; the operation outputs are only written on a launch
         if (cmd_vld_q) begin
            if (ld_wr_hi_s) begin wr_addr_q[23:8]  <= cmd_q[15:0]; wr_hi_v_q <= 1'b1; end
            if (ld_wr_lo_s) begin wr_addr_q[7:0]   <= cmd_q[15:8]; wr_lo_v_q <= 1'b1; end
            if (ld_rd_hi_s) begin rd_addr_q[23:8]  <= cmd_q[15:0]; rd_hi_v_q <= 1'b1; end
            if (ld_rd_lo_s) begin rd_addr_q[7:0]   <= cmd_q[15:8]; rd_lo_v_q <= 1'b1; end
            if (ld_es_hi_s) begin er_start_q[23:8] <= cmd_q[15:0]; es_hi_v_q <= 1'b1; end
            if (ld_es_lo_s) begin er_start_q[7:0]  <= cmd_q[15:8]; es_lo_v_q <= 1'b1; end
            if (ld_ee_hi_s) begin er_end_q[23:8]   <= cmd_q[15:0]; ee_hi_v_q <= 1'b1; end
            if (ld_ee_lo_s) begin er_end_q[7:0]    <= cmd_q[15:8]; ee_lo_v_q <= 1'b1; end
         end

         case (state_q)
            S_IDLE: begin
               // Later assignments override the flag sets made above
               if (acc_wr_s) begin
                  op_type_q     <= 2'b01;
                  op_addr_q     <= wr_addr_q;
                  op_end_addr_q <= wr_addr_q;
                  wr_hi_v_q     <= 1'b0;
                  wr_lo_v_q     <= 1'b0;
               end else if (acc_rd_s) begin
                  op_type_q     <= 2'b10;
                  op_addr_q     <= rd_launch_addr_s;
                  op_end_addr_q <= rd_launch_addr_s;
                  rd_hi_v_q     <= 1'b0;
                  rd_lo_v_q     <= 1'b0;
               end else if (acc_er_s) begin
                  op_type_q     <= 2'b11;
                  op_addr_q     <= er_start_q;
                  op_end_addr_q <= er_end_new_s;
                  es_hi_v_q     <= 1'b0;
                  es_lo_v_q     <= 1'b0;
                  ee_hi_v_q     <= 1'b0;
                  ee_lo_v_q     <= 1'b0;
               end
               if (acc_wr_s | acc_rd_s | acc_er_s) begin
                  op_start_q <= 1'b1;
                  busy_q     <= 1'b1;
                  cnt_q      <= 32'd0;
                  state_q    <= S_RUN;
               end
            end
            S_RUN: begin
               // Completion takes priority over a coincident timeout
               if (bus.op_done) begin
                  op_type_q <= 2'b00;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end else if (cnt_q == TIMEOUT_CYC - 32'd1) begin
                  op_type_q    <= 2'b00;
                  op_timeout_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= S_IDLE;
               end else if (cnt_q != TIMEOUT_CYC) begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.op_start    = op_start_q;
   assign bus.op_type     = op_type_q;
   assign bus.op_addr     = op_addr_q;
   assign bus.op_end_addr = op_end_addr_q;
   assign bus.busy        = busy_q;
   assign bus.cmd_err     = cmd_err_q;
   assign bus.op_timeout  = op_timeout_q;

endmodule

// File: tb/tb_flash_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_flash_cmd_decoder
// Scoreboard bench: each command is run through a reference model that
// predicts the resulting event (launch, reject or nothing); a negedge monitor
// pops and compares whenever the decoder pulses op_start/cmd_err/op_timeout.
// ---------------------------------------------------------------------------
module tb_flash_cmd_decoder;

   localparam int KIND_START = 0;
   localparam int KIND_ERR   = 1;
   localparam int KIND_TO    = 2;

   typedef struct {
      int          kind;
      logic [1:0]  typ;
      logic [23:0] addr;
      logic [23:0] eaddr;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   flash_cmd_decoder_if bus ();

   flash_cmd_decoder #(.TIMEOUT_CYC(32'd100)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   start_cyc = 0;

   // Reference model: address shadows per region (0 wr, 1 rd, 2 erase start, 3 erase end)
   logic [23:0] sh [4];
   bit          vh [4];
   bit          vl [4];
   bit          mrun;
   int          run_cmds;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic [1:0] t, input logic [23:0] a, input logic [23:0] e);
      exp_t x;
      x.kind = kind; x.typ = t; x.addr = a; x.eaddr = e;
      sbq.push_back(x);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         sh[i] = 24'd0; vh[i] = 1'b0; vl[i] = 1'b0;
      end
      mrun = 1'b0;
      run_cmds = 0;
   endtask

   task automatic model_cmd(input logic [31:0] c);
      logic [7:0]  op;
      logic [7:0]  sub;
      logic [15:0] pl;
      int r;
      int launch;
      bit hi;
      bit known;
      bit ok;
      op = c[31:24]; sub = c[23:16]; pl = c[15:0];
      r = -1; launch = 0; hi = 1'b0; known = 1'b1; ok = 1'b0;
      if (op == 8'hAF && sub < 8'd2) begin
         r = 0; hi = (sub == 8'd0);
      end else if (op == 8'hAD && sub < 8'd2) begin
         r = 1; hi = (sub == 8'd0);
         if (sub == 8'd1) launch = 2;
      end else if (op == 8'hAE && sub < 8'd4) begin
         r = (sub < 8'd2) ? 2 : 3; hi = (sub[0] == 1'b0);
         if (sub == 8'd3) launch = 3;
      end else if (op == 8'hA0 && sub == 8'd0) begin
         launch = 1;
      end else begin
         known = 1'b0;
      end
      if (r >= 0) begin
         if (hi) begin sh[r][23:8] = pl;       vh[r] = 1'b1; end
         else    begin sh[r][7:0]  = pl[15:8]; vl[r] = 1'b1; end
      end
      if (!known) begin
         push(KIND_ERR, 2'b00, 24'd0, 24'd0);
      end else if (launch != 0) begin
         case (launch)
            1: ok = vh[0] && vl[0];
            2: ok = vh[1];
            default: ok = vh[2] && vl[2] && vh[3] && vl[3] && (sh[3] >= sh[2]);
         endcase
         if (ok && !mrun) begin
            if (launch == 3) begin
               push(KIND_START, 2'b11, sh[2], sh[3]);
               vh[2] = 1'b0; vl[2] = 1'b0; vh[3] = 1'b0; vl[3] = 1'b0;
            end else begin
               push(KIND_START, 2'(launch), sh[launch-1], sh[launch-1]);
               vh[launch-1] = 1'b0; vl[launch-1] = 1'b0;
            end
            mrun = 1'b1;
            run_cmds = 0;
         end else begin
            push(KIND_ERR, 2'b00, 24'd0, 24'd0);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] c);
      model_cmd(c);
      bus.cmd = c;
      bus.start_cmd = 1'b1;
      repeat (4) tick();
      bus.start_cmd = 1'b0;
      bus.cmd = $urandom;
      repeat (4) tick();
   endtask

   task automatic done();
      bus.op_done = 1'b1;
      tick();
      bus.op_done = 1'b0;
      tick();
      mrun = 1'b0;
   endtask

   task automatic check_idle_outputs(input string name);
      check(name, {bus.op_start, bus.op_type, bus.op_addr, bus.op_end_addr,
                   bus.busy, bus.cmd_err, bus.op_timeout}, 64'd0);
   endtask

   // Monitor: every output pulse must match the oldest predicted event
   exp_t mon_e;
   int   mon_k;
   always @(negedge clk) begin
      if (!rst && (bus.op_start || bus.cmd_err || bus.op_timeout)) begin
         check("one_pulse", $countones({bus.op_start, bus.cmd_err, bus.op_timeout}), 1);
         mon_k = bus.op_start ? KIND_START : (bus.cmd_err ? KIND_ERR : KIND_TO);
         check("event_expected", sbq.size() > 0, 1'b1);
         if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            check("event_kind", mon_k, mon_e.kind);
            if (mon_e.kind == KIND_START) begin
               check("op_type", bus.op_type, mon_e.typ);
               check("op_addr", bus.op_addr, mon_e.addr);
               check("op_end_addr", bus.op_end_addr, mon_e.eaddr);
               check("busy_on_start", bus.busy, 1'b1);
               start_cyc = cyc;
            end else if (mon_e.kind == KIND_TO) begin
               check("timeout_latency", cyc - start_cyc, 100);
               check("timeout_idle", {bus.busy, bus.op_type}, 3'b000);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [31:0] c;
      logic [7:0]  op;
      int pick;
      bus.cmd = 32'd0;
      bus.start_cmd = 1'b0;
      bus.op_done = 1'b0;
      rst = 1'b1;
      model_reset();
      repeat (3) tick();
      check_idle_outputs("reset_outputs_in_reset");
      rst = 1'b0;
      tick();
      check_idle_outputs("reset_outputs_after_release");

      // Rejections with nothing in flight
      send(32'hA000_0000);
      send(32'hAE00_0108); send(32'hAE01_0400); send(32'hAE02_0108); send(32'hAE03_0300);
      send(32'h5500_0000);
      check("busy_after_errors", bus.busy, 1'b0);

      // Write, then reject a read launch while it is in flight
      send(32'hAF00_0108); send(32'hAF01_0400); send(32'hA000_0000);
      check("wr_busy", bus.busy, 1'b1);
      check("wr_type", bus.op_type, 2'b01);
      check("wr_addr", {bus.op_addr, bus.op_end_addr}, {24'h010804, 24'h010804});
      send(32'hAD00_0203); send(32'hAD01_0500);
      check("addr_held_while_busy", bus.op_addr, 24'h010804);
      done();
      check("wr_done_idle", {bus.busy, bus.op_type}, 3'b000);
      check("addr_held_after_done", bus.op_addr, 24'h010804);
      send(32'hAD01_0500);
      check("relaunch_read", {bus.op_type, bus.op_addr}, {2'b10, 24'h020305});
      done();

      // Read, then erase
      send(32'hAD00_0108); send(32'hAD01_0400);
      check("rd_type_addr", {bus.op_type, bus.op_addr}, {2'b10, 24'h010804});
      done();
      send(32'hAE00_0108); send(32'hAE01_0400); send(32'hAE02_0108); send(32'hAE03_0500);
      check("er_addrs", {bus.op_type, bus.op_addr, bus.op_end_addr}, {2'b11, 24'h010804, 24'h010805});
      done();

      // Timeout with no op_done
      send(32'hAF00_0108); send(32'hAF01_0400); send(32'hA000_0000);
      push(KIND_TO, 2'b00, 24'd0, 24'd0);
      mrun = 1'b0;
      repeat (110) tick();
      check("busy_after_timeout", bus.busy, 1'b0);

      // op_done on the timeout cycle: completion, no timeout pulse
      send(32'hAF00_0108); send(32'hAF01_0400); send(32'hA000_0000);
      n = start_cyc + 99 - cyc;
      repeat (n) tick();
      bus.op_done = 1'b1;
      tick();
      bus.op_done = 1'b0;
      mrun = 1'b0;
      check("done_beats_timeout", {bus.busy, bus.op_type, bus.op_timeout}, 4'b0000);
      repeat (105) tick();

      // Async reset in the middle of RUN, start_cmd held high across release
      send(32'hAF00_0108); send(32'hAF01_0400); send(32'hA000_0000);
      check("busy_before_async_rst", bus.busy, 1'b1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      bus.cmd = 32'h5500_0000;
      bus.start_cmd = 1'b1;
      #1;
      check_idle_outputs("async_reset_outputs");
      model_reset();
      repeat (2) tick();
      rst = 1'b0;
      repeat (3) tick();
      done();
      repeat (3) tick();
      check_idle_outputs("after_reset_ignores_done_and_held_start");
      bus.start_cmd = 1'b0;
      repeat (2) tick();

      // Randomised traffic
      for (int i = 0; i < 200; i++) begin
         pick = $urandom_range(0, 9);
         case (pick)
            0, 1, 2: op = 8'hAF;
            3, 4, 5: op = 8'hAD;
            6, 7:    op = 8'hAE;
            8:       op = 8'hA0;
            default: op = 8'($urandom);
         endcase
         c = {op, 8'($urandom_range(0, 3)), 16'($urandom_range(0, 16'h03FF))};
         send(c);
         check("busy_track", bus.busy, mrun);
         if (mrun) begin
            run_cmds++;
            if ($urandom_range(0, 2) == 0 || run_cmds >= 5) done();
         end else if ($urandom_range(0, 7) == 0) begin
            done();
         end
      end
      if (mrun) done();

      repeat (5) tick();
      check("scoreboard_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
